// File: rtl/dma_remote_req_gen_fsm_pkg.sv
// Shared types and constants for the remote-side DMA request generator.
package dma_remote_req_gen_fsm_pkg;

    localparam int unsigned dma_data_width_lp      = 32;
    localparam int unsigned dma_addr_width_lp      = 16;
    localparam int unsigned dma_x_cord_width_lp    = 6;
    localparam int unsigned dma_y_cord_width_lp    = 5;
    localparam int unsigned dma_mask_width_lp      = dma_data_width_lp >> 3;
    localparam int unsigned dma_num_bytes_width_lp = 12;
    localparam int unsigned dma_word_idx_width_lp  = 10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PUSH = 2'd1,
        PULL = 2'd2,
        DONE = 2'd3
    } dma_remote_state_e;

    typedef struct packed {
        logic                           w;
        logic [dma_x_cord_width_lp-1:0] x;
        logic [dma_y_cord_width_lp-1:0] y;
        logic [dma_addr_width_lp-1:0]   addr;
        logic [dma_data_width_lp-1:0]   data;
        logic [dma_mask_width_lp-1:0]   mask;
    } dma_remote_req_s;

    // Byte length to whole words; a trailing partial word is dropped.
    function automatic logic [dma_word_idx_width_lp-1:0] dma_bytes_to_words(
        input logic [dma_num_bytes_width_lp-1:0] num_bytes
    );
        return dma_word_idx_width_lp'(num_bytes >> 2);
    endfunction

endpackage

// File: rtl/dma_remote_req_gen_fsm_if.sv
// Push-data input and remote request output channel of the remote DMA request generator.
interface dma_remote_req_gen_fsm_if
    import dma_remote_req_gen_fsm_pkg::*;
#(
    parameter int unsigned data_width_p   = dma_data_width_lp,
    parameter int unsigned addr_width_p   = dma_addr_width_lp,
    parameter int unsigned x_cord_width_p = dma_x_cord_width_lp,
    parameter int unsigned y_cord_width_p = dma_y_cord_width_lp
);

    logic                        in_data_v_i;
    logic [data_width_p-1:0]     in_data_i;
    logic                        in_data_yumi_o;

    logic                        out_v_o;
    logic                        out_w_o;
    logic [x_cord_width_p-1:0]   out_x_o;
    logic [y_cord_width_p-1:0]   out_y_o;
    logic [addr_width_p-1:0]     out_addr_o;
    logic [data_width_p-1:0]     out_data_o;
    logic [(data_width_p>>3)-1:0] out_mask_o;
    logic                        out_yumi_i;

    modport master (
        input  in_data_v_i, in_data_i, out_yumi_i,
        output in_data_yumi_o, out_v_o, out_w_o, out_x_o, out_y_o,
               out_addr_o, out_data_o, out_mask_o
    );

    modport slave (
        output in_data_v_i, in_data_i, out_yumi_i,
        input  in_data_yumi_o, out_v_o, out_w_o, out_x_o, out_y_o,
               out_addr_o, out_data_o, out_mask_o
    );

endinterface

// File: rtl/dma_remote_req_gen_fsm.sv
// Remote-side DMA request generator: one remote store per pushed word, or one remote load
// per pulled word, with completion reported once the last request has been consumed.
module dma_remote_req_gen_fsm
    import dma_remote_req_gen_fsm_pkg::*;
#(
    parameter int unsigned data_width_p   = dma_data_width_lp,
    parameter int unsigned addr_width_p   = dma_addr_width_lp,
    parameter int unsigned x_cord_width_p = dma_x_cord_width_lp,
    parameter int unsigned y_cord_width_p = dma_y_cord_width_lp
)
(
    input  logic                              clk_i,
    input  logic                              reset_i,
    input  logic                              start_remote_req_i,
    input  logic                              push_not_pull_i,
    input  logic [x_cord_width_p-1:0]         remote_x_i,
    input  logic [y_cord_width_p-1:0]         remote_y_i,
    input  logic [addr_width_p-1:0]           remote_epa_base_i,
    input  logic [dma_num_bytes_width_lp-1:0] num_bytes_i,
    output logic                              all_remote_req_sent_o,
    dma_remote_req_gen_fsm_if.master          bus
);

    localparam int unsigned mask_width_lp = data_width_p >> 3;

    dma_remote_state_e                  state_q, state_d;
    logic [dma_word_idx_width_lp-1:0]   idx_q, idx_d;
    logic [dma_word_idx_width_lp-1:0]   total_q, total_d;
    logic [x_cord_width_p-1:0]          x_q, x_d;
    logic [y_cord_width_p-1:0]          y_q, y_d;
    logic [addr_width_p-1:0]            base_q, base_d;
    dma_remote_req_s                    req_q, req_d;
    logic                               out_v_q, out_v_d;
    logic                               all_sent_q;

    logic                               slot_free_c;
    logic                               more_words_c;
    logic                               in_data_yumi_c;
    logic [dma_word_idx_width_lp-1:0]   start_words_c;
    logic [addr_width_p-1:0]            next_addr_c;

    assign slot_free_c   = ~out_v_q | bus.out_yumi_i;
    assign more_words_c  = (idx_q < total_q);
    assign start_words_c = dma_bytes_to_words(num_bytes_i);
    assign next_addr_c   = addr_width_p'(base_q + addr_width_p'(idx_q));

    // Next-state, counter and output-register load decisions.
    always_comb begin
        state_d        = state_q;
        idx_d          = idx_q;
        total_d        = total_q;
        x_d            = x_q;
        y_d            = y_q;
        base_d         = base_q;
        req_d          = req_q;
        out_v_d        = out_v_q & ~bus.out_yumi_i;
        in_data_yumi_c = 1'b0;

        case (state_q)
            IDLE: begin
                if (start_remote_req_i) begin
                    x_d     = remote_x_i;
                    y_d     = remote_y_i;
                    base_d  = remote_epa_base_i;
                    total_d = start_words_c;
                    idx_d   = '0;
                    if (start_words_c == '0) begin
                        state_d = DONE;
                    end else if (push_not_pull_i) begin
                        state_d = PUSH;
                    end else begin
                        state_d = PULL;
                    end
                end
            end

            PUSH: begin
                if (slot_free_c && bus.in_data_v_i && more_words_c) begin
                    in_data_yumi_c = 1'b1;
                    out_v_d        = 1'b1;
                    req_d.w        = 1'b1;
                    req_d.x        = x_q;
                    req_d.y        = y_q;
                    req_d.addr     = next_addr_c;
                    req_d.data     = data_width_p'(bus.in_data_i);
                    req_d.mask     = {mask_width_lp{1'b1}};
                    idx_d          = idx_q + dma_word_idx_width_lp'(1);
                end else if (slot_free_c && !more_words_c) begin
                    state_d = DONE;
                end
            end

            PULL: begin
                if (slot_free_c && more_words_c) begin
                    out_v_d    = 1'b1;
                    req_d.w    = 1'b0;
                    req_d.x    = x_q;
                    req_d.y    = y_q;
                    req_d.addr = next_addr_c;
                    req_d.data = '0;
                    req_d.mask = {mask_width_lp{1'b1}};
                    idx_d      = idx_q + dma_word_idx_width_lp'(1);
                end else if (slot_free_c && !more_words_c) begin
                    state_d = DONE;
                end
            end

            DONE: begin
                // Stay here while start is still held so one start level yields one transfer.
                if (!start_remote_req_i) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, counter, latched transfer parameters and output request register.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            total_q    <= '0;
            x_q        <= '0;
            y_q        <= '0;
            base_q     <= '0;
            req_q      <= '0;
            out_v_q    <= 1'b0;
            all_sent_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            total_q    <= total_d;
            x_q        <= x_d;
            y_q        <= y_d;
            base_q     <= base_d;
            req_q      <= req_d;
            out_v_q    <= out_v_d;
            all_sent_q <= (state_d == DONE);
        end
    end

    assign all_remote_req_sent_o = all_sent_q;
    assign bus.in_data_yumi_o    = in_data_yumi_c;
    assign bus.out_v_o           = out_v_q;
    assign bus.out_w_o           = req_q.w;
    assign bus.out_x_o           = req_q.x;
    assign bus.out_y_o           = req_q.y;
    assign bus.out_addr_o        = req_q.addr;
    assign bus.out_data_o        = req_q.data;
    assign bus.out_mask_o        = req_q.mask;

endmodule

// File: tb/tb_dma_remote_req_gen_fsm.sv
// Directed bench for dma_remote_req_gen_fsm with a request-queue model checked every cycle.
module tb_dma_remote_req_gen_fsm;
    import dma_remote_req_gen_fsm_pkg::*;

    typedef struct {
        logic        w;
        logic [5:0]  x;
        logic [4:0]  y;
        logic [15:0] addr;
        logic [31:0] data;
    } exp_req_t;

    logic        clk = 1'b0;
    logic        reset_i;
    logic        start_remote_req_i;
    logic        push_not_pull_i;
    logic [5:0]  remote_x_i;
    logic [4:0]  remote_y_i;
    logic [15:0] remote_epa_base_i;
    logic [11:0] num_bytes_i;
    logic        all_remote_req_sent_o;

    dma_remote_req_gen_fsm_if bus ();

    dma_remote_req_gen_fsm dut (
        .clk_i                 (clk),
        .reset_i               (reset_i),
        .start_remote_req_i    (start_remote_req_i),
        .push_not_pull_i       (push_not_pull_i),
        .remote_x_i            (remote_x_i),
        .remote_y_i            (remote_y_i),
        .remote_epa_base_i     (remote_epa_base_i),
        .num_bytes_i           (num_bytes_i),
        .all_remote_req_sent_o (all_remote_req_sent_o),
        .bus                   (bus)
    );

    always #5 clk = ~clk;

    int          checks   = 0;
    int          failures = 0;
    exp_req_t    exp_q[$];
    logic [31:0] pd_q[$];
    logic [31:0] feed_d[16];
    int          feed_n   = 0;
    int          feed_k   = 0;
    bit          feed_extra = 1'b0;
    int          stall_n  = 0;
    int          wait_cnt = 0;
    bit          mode_push = 1'b0;
    int          hs_count = 0;
    logic [15:0] hs_addr[256];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // Model: every visible request must be the oldest outstanding expected request.
    always @(negedge clk) begin
        if (!reset_i) begin
            if (bus.out_v_o) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_req", bus.out_v_o, 1'b0);
                end else begin
                    chk("req_w",    bus.out_w_o,    exp_q[0].w);
                    chk("req_x",    bus.out_x_o,    exp_q[0].x);
                    chk("req_y",    bus.out_y_o,    exp_q[0].y);
                    chk("req_addr", bus.out_addr_o, exp_q[0].addr);
                    chk("req_data", bus.out_data_o, exp_q[0].data);
                    chk("req_mask", bus.out_mask_o, 4'hF);
                    if (bus.out_yumi_i) begin
                        hs_addr[hs_count[7:0]] = bus.out_addr_o;
                        hs_count++;
                        void'(exp_q.pop_front());
                    end
                end
            end
            if (!mode_push) begin
                chk("pull_in_yumi", bus.in_data_yumi_o, 1'b0);
            end else if (bus.in_data_yumi_o) begin
                if (pd_q.size() == 0) begin
                    chk("extra_in_yumi", bus.in_data_yumi_o, 1'b0);
                end else begin
                    chk("push_in_data", bus.in_data_i, pd_q[0]);
                    void'(pd_q.pop_front());
                end
            end
            if (all_remote_req_sent_o) chk("done_out_v", bus.out_v_o, 1'b0);
            if (exp_q.size() != 0) chk("early_done", all_remote_req_sent_o, 1'b0);
        end
    end

    // One clock: capture handshakes before the edge, update feeder/yumi just after it.
    task automatic tick();
        bit take;
        bit hs;
        @(negedge clk);
        take = bus.in_data_yumi_o;
        hs   = bus.out_v_o & bus.out_yumi_i;
        @(posedge clk);
        #1;
        if (take) begin
            feed_k++;
            if (feed_k < feed_n) begin
                bus.in_data_i = feed_d[feed_k];
            end else begin
                bus.in_data_v_i = feed_extra;
                bus.in_data_i   = 32'hDEAD_BEEF;
            end
        end
        if (hs) wait_cnt = 0;
        if (stall_n == 0) begin
            bus.out_yumi_i = 1'b1;
        end else if (bus.out_v_o) begin
            bus.out_yumi_i = (wait_cnt >= stall_n);
            wait_cnt++;
        end else begin
            bus.out_yumi_i = 1'b0;
            wait_cnt = 0;
        end
    endtask

    task automatic start_xfer(input bit p, input logic [5:0] x, input logic [4:0] y,
                              input logic [15:0] b, input logic [11:0] nb, input int stall);
        int n;
        exp_req_t e;
        n = int'(nb >> 2);
        for (int i = 0; i < n; i++) begin
            e.w    = p;
            e.x    = x;
            e.y    = y;
            e.addr = 16'(b + 16'(i));
            e.data = p ? feed_d[i] : 32'h0;
            exp_q.push_back(e);
            if (p) pd_q.push_back(feed_d[i]);
        end
        mode_push          = p;
        feed_n             = p ? n : 0;
        feed_k             = 0;
        bus.in_data_v_i    = p ? (n > 0) : 1'b1;
        bus.in_data_i      = feed_d[0];
        stall_n            = stall;
        wait_cnt           = 0;
        bus.out_yumi_i     = (stall == 0);
        push_not_pull_i    = p;
        remote_x_i         = x;
        remote_y_i         = y;
        remote_epa_base_i  = b;
        num_bytes_i        = nb;
        start_remote_req_i = 1'b1;
    endtask

    task automatic wait_done(input string name, input int bound);
        int c = 0;
        while (!all_remote_req_sent_o && c < bound) begin
            tick();
            c++;
        end
        chk({name, "_done"},    all_remote_req_sent_o, 1'b1);
        chk({name, "_drained"}, exp_q.size(), 0);
        chk({name, "_pd_used"}, pd_q.size(), 0);
    endtask

    task automatic end_xfer(input string name);
        start_remote_req_i = 1'b0;
        bus.in_data_v_i    = 1'b0;
        tick();
        chk({name, "_idle"}, all_remote_req_sent_o, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end

    initial begin
        int h0;
        int c;
        reset_i            = 1'b1;
        start_remote_req_i = 1'b0;
        push_not_pull_i    = 1'b0;
        remote_x_i         = '0;
        remote_y_i         = '0;
        remote_epa_base_i  = '0;
        num_bytes_i        = '0;
        bus.in_data_v_i    = 1'b0;
        bus.in_data_i      = '0;
        bus.out_yumi_i     = 1'b0;
        repeat (3) tick();
        chk("rst_out_v",   bus.out_v_o, 1'b0);
        chk("rst_done",    all_remote_req_sent_o, 1'b0);
        chk("rst_in_yumi", bus.in_data_yumi_o, 1'b0);
        chk("rst_addr",    bus.out_addr_o, 16'h0);
        chk("rst_data",    bus.out_data_o, 32'h0);
        chk("rst_mask",    bus.out_mask_o, 4'h0);
        reset_i = 1'b0;
        tick();

        // 1: 16B push, yumi tied high, data back-to-back.
        feed_d[0] = 32'hA000_000A; feed_d[1] = 32'hB000_000B;
        feed_d[2] = 32'hC000_000C; feed_d[3] = 32'hD000_000D;
        h0 = hs_count;
        start_xfer(1'b1, 6'd2, 5'd3, 16'h0100, 12'd16, 0);
        tick();
        chk("t1_no_req_yet", bus.out_v_o, 1'b0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("t1_v",    bus.out_v_o, 1'b1);
            chk("t1_addr", bus.out_addr_o, 16'(16'h0100 + 16'(i)));
            chk("t1_data", bus.out_data_o, feed_d[i]);
        end
        tick();
        chk("t1_done_next", all_remote_req_sent_o, 1'b1);
        chk("t1_v_off",     bus.out_v_o, 1'b0);
        chk("t1_count",     hs_count - h0, 4);
        end_xfer("t1");

        // 2: 12B pull, yumi held low 3 cycles per request, in_data_v_i high throughout.
        h0 = hs_count;
        start_xfer(1'b0, 6'd5, 5'd7, 16'h0040, 12'd12, 3);
        tick();
        tick();
        chk("t2_v",          bus.out_v_o, 1'b1);
        chk("t2_addr",       bus.out_addr_o, 16'h0040);
        chk("t2_w",          bus.out_w_o, 1'b0);
        chk("t2_data",       bus.out_data_o, 32'h0);
        tick();
        chk("t2_stall_v",    bus.out_v_o, 1'b1);
        chk("t2_stall_addr", bus.out_addr_o, 16'h0040);
        wait_done("t2", 60);
        chk("t2_count", hs_count - h0, 3);
        end_xfer("t2");

        // 3: zero-length transfer, then a 6B one (rounds down to one word).
        h0 = hs_count;
        start_xfer(1'b1, 6'd1, 5'd1, 16'h0010, 12'd0, 0);
        tick();
        chk("t3_zero_done", all_remote_req_sent_o, 1'b1);
        chk("t3_zero_v",    bus.out_v_o, 1'b0);
        end_xfer("t3a");
        feed_d[0] = 32'h0000_1234;
        start_xfer(1'b1, 6'd1, 5'd1, 16'h0020, 12'd6, 0);
        wait_done("t3b", 20);
        chk("t3_count", hs_count - h0, 1);
        end_xfer("t3b");

        // 4: address wrap from 0xFFFE.
        for (int i = 0; i < 4; i++) feed_d[i] = $urandom;
        h0 = hs_count;
        start_xfer(1'b1, 6'd4, 5'd4, 16'hFFFE, 12'd16, 0);
        wait_done("t4", 30);
        chk("t4_addr0", hs_addr[h0[7:0]], 16'hFFFE);
        chk("t4_addr2", hs_addr[8'(h0 + 2)], 16'h0000);
        chk("t4_addr3", hs_addr[8'(h0 + 3)], 16'h0001);
        end_xfer("t4");

        // 5: extra push data after the last word; start held high in DONE.
        feed_d[0] = 32'h5555_0001; feed_d[1] = 32'h5555_0002;
        feed_extra = 1'b1;
        h0 = hs_count;
        start_xfer(1'b1, 6'd9, 5'd9, 16'h0300, 12'd8, 1);
        wait_done("t5", 30);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("t5_hold_done", all_remote_req_sent_o, 1'b1);
            chk("t5_extra_v",   bus.in_data_v_i, 1'b1);
            chk("t5_no_yumi",   bus.in_data_yumi_o, 1'b0);
        end
        chk("t5_count", hs_count - h0, 2);
        feed_extra = 1'b0;
        end_xfer("t5");

        // 6: reset after the 2nd of 4 requests, then a fresh 8B transfer.
        h0 = hs_count;
        start_xfer(1'b0, 6'd3, 5'd2, 16'h0500, 12'd16, 0);
        c = 0;
        while ((hs_count - h0) < 2 && c < 20) begin
            tick();
            c++;
        end
        chk("t6_reached_two", hs_count - h0, 2);
        reset_i            = 1'b1;
        start_remote_req_i = 1'b0;
        tick();
        reset_i = 1'b0;
        exp_q.delete();
        pd_q.delete();
        chk("t6_rst_v",    bus.out_v_o, 1'b0);
        chk("t6_rst_done", all_remote_req_sent_o, 1'b0);
        tick();
        chk("t6_idle_v",   bus.out_v_o, 1'b0);
        h0 = hs_count;
        start_xfer(1'b0, 6'd6, 5'd6, 16'h0600, 12'd8, 0);
        wait_done("t6", 20);
        chk("t6_count", hs_count - h0, 2);
        chk("t6_addr0", hs_addr[h0[7:0]], 16'h0600);
        chk("t6_addr1", hs_addr[8'(h0 + 1)], 16'h0601);
        end_xfer("t6");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
